// File: rtl/coax_tx_engine.sv
// coax_tx_engine: queued 10-bit words sent as Manchester frames (quiesce, violation, words, end-of-message).
module coax_tx_engine #(
  parameter int DIV   = 3,
  parameter int DEPTH = 32,
  parameter int DLY   = 6
) (
  input  logic                     sclk12,
  input  logic                     rst,
  input  logic [9:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     start,
  input  logic                     clr_ovf,
  output logic                     serial_out,
  output logic                     serial_out_dly,
  output logic                     tx_active,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  typedef enum logic [2:0] {IDLE, QUIESCE, VIOL, WORD, EOM} state_t;
  state_t         state_q, state_d;
  logic [7:0]     div_q, div_d;
  logic [4:0]     hb_q, hb_d, hb_last;
  logic [11:0]    wq_q, wq_d;
  logic [9:0]     mem [DEPTH];
  logic [AW-1:0]  wp_q, rp_q;
  logic [LW-1:0]  level_q;
  logic           ovf_q;
  logic [DLY-1:0] dly_q;
  logic [DLY:0]   dly_in;
  logic           full, push, pop, tick, done;
  assign full     = level_q == LW'(DEPTH);
  assign wr_ready = ~full;
  assign push     = wr_valid & ~full;
  assign tick     = div_q == DIV_M1;
  assign hb_last  = state_q == QUIESCE ? 5'd9 : state_q == VIOL ? 5'd5 : state_q == WORD ? 5'd23 : 5'd7;
  assign done     = tick && hb_q == hb_last;
  // Word frame: sync 1, data MSB first, even parity over the data bits
  assign wq_d     = pop ? {1'b1, mem[rp_q], ^mem[rp_q]} : wq_q;
  assign tx_active = state_q != IDLE;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign dly_in    = {dly_q, serial_out};
  assign serial_out_dly = dly_in[DLY];
  assign serial_out = state_q == QUIESCE ? ~hb_q[0] :
                      state_q == VIOL    ? hb_q < 5'd3 :
                      state_q == WORD    ? wq_q[4'd11 - hb_q[4:1]] ^ hb_q[0] :
                      state_q == EOM     ? (hb_q >= 5'd1 && hb_q <= 5'd4) : 1'b0;
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hb_d    = hb_q;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      if (start && level_q != '0) begin
        state_d = QUIESCE;
        div_d   = '0;
        hb_d    = '0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 8'd1;
      hb_d  = tick ? (done ? '0 : hb_q + 5'd1) : hb_q;
      if (done) begin
        state_d = state_q == QUIESCE ? VIOL :
                  state_q == VIOL    ? WORD :
                  state_q == WORD    ? (level_q != '0 ? WORD : EOM) : IDLE;
        pop     = state_d == WORD;
      end
    end
  end
  always_ff @(posedge sclk12 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      hb_q    <= '0;
      wq_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hb_q    <= hb_d;
      wq_q    <= wq_d;
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      level_q <= level_q + LW'(push) - LW'(pop);
      ovf_q   <= (wr_valid & full) | (ovf_q & ~clr_ovf);
      dly_q   <= dly_in[DLY-1:0];
    end
  end
  always_ff @(posedge sclk12) begin
    if (push) mem[wp_q] <= wr_data;
  end
endmodule

// File: doc/coax_tx_engine.md
COAX_TX_ENGINE -- requirements
Module: coax_tx_engine

Interface
REQ-001 SHALL have parameter DIV, default 3, sclk12 cycles per half-bit (legal 2..255).
REQ-002 SHALL have parameter DEPTH, default 32, TX word FIFO depth (power of two, 4..256).
REQ-003 SHALL have parameter DLY, default 6, serial_out_dly delay in sclk12 cycles (legal 1..64).
REQ-004 SHALL have port sclk12  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_data  in  10  TX word.
REQ-007 SHALL have port wr_valid  in  1  write strobe; accepted when wr_valid && wr_ready.
REQ-008 SHALL have port wr_ready  out  1  ~fifo_full.
REQ-009 SHALL have port start  in  1  single-cycle frame start request.
REQ-010 SHALL have port clr_ovf  in  1  clears ovf.
REQ-011 SHALL have port serial_out  out  1  Manchester line output.
REQ-012 SHALL have port serial_out_dly  out  1  serial_out delayed DLY cycles.
REQ-013 SHALL have port tx_active  out  1  frame in progress.
REQ-014 SHALL have port level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have port ovf  out  1  sticky write-while-full flag.

Function
REQ-016 SHALL encode bit 1 as half-bit high then low; bit 0 as low then high; each half-bit exactly DIV cycles.
REQ-017 SHALL hold serial_out low while idle.
REQ-018 SHALL use FSM IDLE -> QUIESCE -> VIOL -> WORD -> (WORD | EOM) -> IDLE.
REQ-019 SHALL accept start only in IDLE with level != 0; otherwise ignore it, no flag.
REQ-020 SHALL, on accepted start at edge N, drive tx_active=1 and the first QUIESCE half-bit from edge N+1, divider cleared to 0.
REQ-021 SHALL send QUIESCE as five 1 bits (10 half-bits).
REQ-022 SHALL send VIOL as 3 half-bits high then 3 half-bits low.
REQ-023 SHALL send each WORD as 12 bits: sync 1, wr_data[9:0] MSB first, parity = XOR of the 10 data bits (even parity).
REQ-024 SHALL pop the FIFO at the edge the WORD sync half-bit begins; level decrements that edge.
REQ-025 SHALL, at the end of a WORD, go to another WORD if level != 0, else to EOM.
REQ-026 SHALL send EOM as a 0 bit, then 3 half-bits high, then 3 half-bits low (8 half-bits).
REQ-027 SHALL drop tx_active and return serial_out low at the edge after the last EOM half-bit completes.
REQ-028 SHALL count an n-word frame as 24+24n half-bits, i.e. DIV*(24+24n) cycles of tx_active.
REQ-029 SHALL allow FIFO writes during a frame; a word written before the current WORD ends extends the frame.
REQ-030 SHALL, on simultaneous write and pop, update level by net 0; full is judged before the pop, so writes while full are refused even if a pop occurs that cycle.
REQ-031 SHALL set ovf when wr_valid && !wr_ready; write data discarded; clr_ovf clears ovf; a same-cycle set wins.
REQ-032 SHALL implement serial_out_dly as a DLY-stage shift register of serial_out, reset low.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH; level reaches DEPTH when full.

Reset
REQ-034 SHALL, on rst, asynchronously force: FSM IDLE, FIFO empty (level 0, wr_ready 1), ovf 0, tx_active 0, serial_out 0, serial_out_dly pipeline 0, divider 0.
REQ-035 SHALL, on rst mid-frame, abort immediately and discard all queued words; no EOM is sent.

Verification
REQ-036 SHALL cover: DIV=3, write 0x3FF, start -> tx_active high for 144 cycles; word bits 1,1111111111,0; serial_out_dly equals serial_out shifted 6 cycles.
REQ-037 SHALL cover: write 0x001 and 0x155, start -> 2 WORDs, parities 1 and 1, tx_active 216 cycles, level 2->1->0 at sync starts.
REQ-038 SHALL cover: start with empty FIFO -> no activity, serial_out stays 0, ovf 0.
REQ-039 SHALL cover: DEPTH=4, write 5 words with no start -> level 4, wr_ready 0, 5th dropped, ovf 1; clr_ovf -> ovf 0.
REQ-040 SHALL cover: 1 word queued, start, write a second word during the first WORD -> frame carries 2 WORDs; write after EOM begins -> word stays queued, level 1.
REQ-041 SHALL cover: assert rst during VIOL -> serial_out 0, tx_active 0, level 0 within the same cycle; next start with empty FIFO ignored.
